// File: rtl/mux_2x1_8bits_if.sv
// Lane-pair input and serialized byte-stream output of the 2x1 lane combiner.
// The master side is the byte-striping logic; the slave side is the combiner.
interface mux_2x1_8bits_if;
  logic [7:0] data_in0;
  logic       valid_in0;
  logic [7:0] data_in1;
  logic       valid_in1;
  logic       pair_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_out;
  logic       order_err;

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1,
    input  pair_ready, data_out, valid_out, lane_out, order_err
  );

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1,
    output pair_ready, data_out, valid_out, lane_out, order_err
  );
endinterface

// File: rtl/mux_2x1_8bits.sv
// Merges two 8-bit lanes into one byte stream at twice the pair rate.
// Lane 0 goes out first and lane 1 second, using a phase bit instead of a divided clock.
module mux_2x1_8bits #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic            clk2,
  input  logic            reset_L,
  mux_2x1_8bits_if.slave  laneBus
);

  logic       phaseReg;
  logic [7:0] hold1Reg;
  logic       vhold1Reg;
  logic [7:0] dataOutReg;
  logic       validOutReg;
  logic       laneOutReg;
  logic       orderErrReg;

  always_ff @(posedge clk2 or negedge reset_L) begin
    if (!reset_L) begin
      phaseReg    <= 1'b0;
      hold1Reg    <= 8'h00;
      vhold1Reg   <= 1'b0;
      dataOutReg  <= IDLE_BYTE;
      validOutReg <= 1'b0;
      laneOutReg  <= 1'b0;
      orderErrReg <= 1'b0;
    end else begin
      phaseReg <= ~phaseReg;
      if (!phaseReg) begin
        // Sample slot: emit lane 0 now and park lane 1 for the next slot.
        hold1Reg    <= laneBus.data_in1;
        vhold1Reg   <= laneBus.valid_in1;
        dataOutReg  <= laneBus.valid_in0 ? laneBus.data_in0 : IDLE_BYTE;
        validOutReg <= laneBus.valid_in0;
        laneOutReg  <= 1'b0;
        if (laneBus.valid_in1 && !laneBus.valid_in0)
          orderErrReg <= 1'b1;
      end else begin
        dataOutReg  <= vhold1Reg ? hold1Reg : IDLE_BYTE;
        validOutReg <= vhold1Reg;
        laneOutReg  <= 1'b1;
      end
    end
  end

  assign laneBus.pair_ready = ~phaseReg;
  assign laneBus.data_out   = dataOutReg;
  assign laneBus.valid_out  = validOutReg;
  assign laneBus.lane_out   = laneOutReg;
  assign laneBus.order_err  = orderErrReg;

endmodule

// File: tb/tb_mux_2x1_8bits.sv
// Directed bench for mux_2x1_8bits: two instances (idle byte 00 and BC) share stimulus
// and are checked slot by slot against a queue of expected output bytes.
module tb_mux_2x1_8bits;

  logic clk2 = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk2 = ~clk2;

  mux_2x1_8bits_if busA ();
  mux_2x1_8bits_if busB ();

  mux_2x1_8bits dutA (
    .clk2    (clk2),
    .reset_L (reset_L),
    .laneBus (busA)
  );

  mux_2x1_8bits #(.IDLE_BYTE(8'hBC)) dutB (
    .clk2    (clk2),
    .reset_L (reset_L),
    .laneBus (busB)
  );

  typedef struct {
    logic [7:0] dataA;
    logic [7:0] dataB;
    logic       valid;
    logic       lane;
    logic       err;
    string      tag;
  } slot_t;

  slot_t sb[$];
  int    assertCount = 0;
  int    failCount = 0;
  logic  expPhase = 1'b0;
  logic  expErr = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    assertCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [7:0] d0, input logic v0, input logic [7:0] d1, input logic v1);
    busA.data_in0 = d0; busA.valid_in0 = v0; busA.data_in1 = d1; busA.valid_in1 = v1;
    busB.data_in0 = d0; busB.valid_in0 = v0; busB.data_in1 = d1; busB.valid_in1 = v1;
  endtask

  // Drive a pair ahead of a SAMPLE edge and queue the two slots it must produce.
  task automatic pushPair(input string tag, input logic [7:0] d0, input logic v0,
                          input logic [7:0] d1, input logic v1);
    slot_t s;
    drive(d0, v0, d1, v1);
    expErr = expErr | (v1 & ~v0);
    s.dataA = v0 ? d0 : 8'h00; s.dataB = v0 ? d0 : 8'hBC;
    s.valid = v0; s.lane = 1'b0; s.err = expErr; s.tag = {tag, "_l0"};
    sb.push_back(s);
    s.dataA = v1 ? d1 : 8'h00; s.dataB = v1 ? d1 : 8'hBC;
    s.valid = v1; s.lane = 1'b1; s.err = expErr; s.tag = {tag, "_l1"};
    sb.push_back(s);
  endtask

  task automatic tick();
    slot_t s;
    @(posedge clk2);
    #1;
    expPhase = ~expPhase;
    check("pair_ready_a", {7'd0, busA.pair_ready}, {7'd0, ~expPhase});
    check("pair_ready_b", {7'd0, busB.pair_ready}, {7'd0, ~expPhase});
    if (sb.size() == 0) begin
      assertCount++;
      failCount++;
      $error("FAIL scoreboard_underflow observed=empty expected=slot");
    end else begin
      s = sb.pop_front();
      check({s.tag, "_data_a"},  busA.data_out, s.dataA);
      check({s.tag, "_data_b"},  busB.data_out, s.dataB);
      check({s.tag, "_valid_a"}, {7'd0, busA.valid_out}, {7'd0, s.valid});
      check({s.tag, "_valid_b"}, {7'd0, busB.valid_out}, {7'd0, s.valid});
      check({s.tag, "_lane_a"},  {7'd0, busA.lane_out},  {7'd0, s.lane});
      check({s.tag, "_lane_b"},  {7'd0, busB.lane_out},  {7'd0, s.lane});
      check({s.tag, "_err_a"},   {7'd0, busA.order_err}, {7'd0, s.err});
      check({s.tag, "_err_b"},   {7'd0, busB.order_err}, {7'd0, s.err});
      $display("slot %s: A=%02h B=%02h v=%0d lane=%0d err=%0d", s.tag,
               busA.data_out, busB.data_out, busA.valid_out, busA.lane_out, busA.order_err);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_data_a"},  busA.data_out, 8'h00);
    check({tag, "_data_b"},  busB.data_out, 8'hBC);
    check({tag, "_valid_a"}, {7'd0, busA.valid_out}, 8'd0);
    check({tag, "_valid_b"}, {7'd0, busB.valid_out}, 8'd0);
    check({tag, "_lane_a"},  {7'd0, busA.lane_out}, 8'd0);
    check({tag, "_err_a"},   {7'd0, busA.order_err}, 8'd0);
    check({tag, "_err_b"},   {7'd0, busB.order_err}, 8'd0);
    check({tag, "_pr_a"},    {7'd0, busA.pair_ready}, 8'd1);
    $display("reset %s: A=%02h B=%02h v=%0d pr=%0d", tag,
             busA.data_out, busB.data_out, busA.valid_out, busA.pair_ready);
  endtask

  initial begin
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    reset_L = 1'b0;
    repeat (3) begin
      @(posedge clk2);
      #1;
      checkIdle("reset_hold");
    end
    #2 reset_L = 1'b1;
    expPhase = 1'b0;

    pushPair("basic", 8'hA5, 1'b1, 8'h3C, 1'b1);
    tick(); tick();

    for (int i = 0; i < 3; i++) begin
      pushPair("stream", 8'(2 * i + 1), 1'b1, 8'(2 * i + 2), 1'b1);
      tick(); tick();
    end

    pushPair("lane1_invalid", 8'h11, 1'b1, 8'hFF, 1'b0);
    tick(); tick();

    pushPair("both_invalid", 8'h55, 1'b0, 8'h66, 1'b0);
    tick(); tick();

    pushPair("order_err", 8'h99, 1'b0, 8'h77, 1'b1);
    tick(); tick();

    pushPair("after_err", 8'h21, 1'b1, 8'h22, 1'b1);
    tick(); tick();

    // Inputs scrambled during the second slot must not reach the output.
    pushPair("phase1_change", 8'h31, 1'b1, 8'h32, 1'b1);
    tick();
    drive(8'hE0, 1'b0, 8'hE1, 1'b0);
    tick();

    // Reset lands between the lane-0 and lane-1 slots: BB must be dropped.
    pushPair("mid_reset", 8'hAA, 1'b1, 8'hBB, 1'b1);
    tick();
    #2 reset_L = 1'b0;
    #1 checkIdle("async_reset");
    sb.delete();
    expErr = 1'b0;
    expPhase = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) begin
      @(posedge clk2);
      #1;
      checkIdle("reset_again");
    end
    #2 reset_L = 1'b1;

    pushPair("post_reset", 8'h12, 1'b1, 8'h34, 1'b1);
    tick(); tick();

    for (int i = 0; i < 6; i++) begin
      pushPair("random", 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      tick(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
